// File: rtl/des_key_schedule_if.sv
// des_key_schedule_if: key intake and subkey stream handshake for the DES key schedule.
interface des_key_schedule_if;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
  logic        decrypt;
  logic        flush;
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        sk_last;
  logic        parity_err;
  modport master (
    output key_valid, key, decrypt, flush, sk_ready,
    input  key_ready, sk_valid, subkey, round, sk_last, parity_err
  );
  modport slave (
    input  key_valid, key, decrypt, flush, sk_ready,
    output key_ready, sk_valid, subkey, round, sk_last, parity_err
  );
endinterface

// File: rtl/des_key_schedule.sv
// des_key_schedule: streams the 16 DES round keys (encrypt or decrypt order) with ready/valid flow control.
module des_key_schedule #(
  parameter int PARITY_MODE = 1,
  parameter int PARITY_ODD  = 1
) (
  input logic               clk,
  input logic               rst_n,
  des_key_schedule_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, GEN = 2'd1, DONE = 2'd2;
  // bit r set when round r+1 rotates by two
  localparam logic [15:0] SH2 = 16'b0111_1110_1111_1100;
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction
  function automatic logic [27:0] rot(input logic [27:0] x, input logic en, input logic left, input logic two);
    return !en ? x :
           left ? (two ? {x[25:0], x[27:26]} : {x[26:0], x[27]}) :
                  (two ? {x[1:0], x[27:2]}   : {x[0], x[27:1]});
  endfunction
  logic [1:0]  state;
  logic [27:0] c, d, c_nx, d_nx;
  logic        dec, bad, sk_valid_q, sk_last_q, parity_q;
  logic [47:0] subkey_q;
  logic [3:0]  round_q, ri;
  logic [55:0] cd_key;
  always_comb begin
    bad = 1'b0;
    for (int b = 0; b < 8; b++) bad = bad | ((^bus.key[8*b +: 8]) != 1'(PARITY_ODD));
  end
  assign cd_key = pc1(bus.key);
  // decrypt walks the rotations backwards, undoing the shift of the key just sent
  assign ri   = dec ? 4'd15 - round_q : round_q + 4'd1;
  assign c_nx = (state == IDLE) ? rot(cd_key[55:28], !bus.decrypt, 1'b1, 1'b0) : rot(c, 1'b1, !dec, SH2[ri]);
  assign d_nx = (state == IDLE) ? rot(cd_key[27:0], !bus.decrypt, 1'b1, 1'b0) : rot(d, 1'b1, !dec, SH2[ri]);
  assign bus.key_ready  = (state == IDLE) && !bus.flush;
  assign bus.sk_valid   = sk_valid_q;
  assign bus.subkey     = subkey_q;
  assign bus.round      = round_q;
  assign bus.sk_last    = sk_last_q;
  assign bus.parity_err = parity_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      c          <= '0;
      d          <= '0;
      dec        <= 1'b0;
      subkey_q   <= '0;
      round_q    <= '0;
      sk_valid_q <= 1'b0;
      sk_last_q  <= 1'b0;
      parity_q   <= 1'b0;
    end else if (bus.flush) begin
      state      <= IDLE;
      sk_valid_q <= 1'b0;
      sk_last_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.key_valid) begin
        dec      <= bus.decrypt;
        c        <= c_nx;
        d        <= d_nx;
        parity_q <= (PARITY_MODE != 0) && bad;
        if (PARITY_MODE == 2 && bad) begin
          state <= DONE;
        end else begin
          state      <= GEN;
          sk_valid_q <= 1'b1;
          sk_last_q  <= 1'b0;
          round_q    <= '0;
          subkey_q   <= pc2({c_nx, d_nx});
        end
      end
    end else if (state == GEN) begin
      if (bus.sk_ready) begin
        if (round_q == 4'd15) begin
          state      <= DONE;
          sk_valid_q <= 1'b0;
          sk_last_q  <= 1'b0;
        end else begin
          c         <= c_nx;
          d         <= d_nx;
          round_q   <= round_q + 4'd1;
          sk_last_q <= (round_q == 4'd14);
          subkey_q  <= pc2({c_nx, d_nx});
        end
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: table, directed and random checks of des_key_schedule against a textbook DES schedule model.
module tb_des_key_schedule;
  logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic        key_valid = 1'b0, decrypt = 1'b0, flush = 1'b0, sk_ready = 1'b0;
  logic [63:0] key = '0;
  logic        o_key_ready, o_sk_valid, o_sk_last, o_parity_err;
  logic [47:0] o_subkey;
  logic [3:0]  o_round;
  int pass_cnt = 0, chk_cnt = 0;
  logic [47:0] ks [16];
  int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic [47:0] first;
    logic [47:0] last;
  } vec_t;
  vec_t tbl [4];
  logic [63:0] k_bad;

  des_key_schedule_if i1 ();
  des_key_schedule_if i2 ();
  assign i1.key_valid = key_valid & !sel;
  assign i1.key       = key;
  assign i1.decrypt   = decrypt;
  assign i1.flush     = flush;
  assign i1.sk_ready  = sk_ready;
  assign i2.key_valid = key_valid & sel;
  assign i2.key       = key;
  assign i2.decrypt   = decrypt;
  assign i2.flush     = flush;
  assign i2.sk_ready  = sk_ready;
  assign o_key_ready  = sel ? i2.key_ready  : i1.key_ready;
  assign o_sk_valid   = sel ? i2.sk_valid   : i1.sk_valid;
  assign o_sk_last    = sel ? i2.sk_last    : i1.sk_last;
  assign o_parity_err = sel ? i2.parity_err : i1.parity_err;
  assign o_subkey     = sel ? i2.subkey     : i1.subkey;
  assign o_round      = sel ? i2.round      : i1.round;

  des_key_schedule #(.PARITY_MODE(1), .PARITY_ODD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  des_key_schedule #(.PARITY_MODE(2), .PARITY_ODD(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, got, exp);
  endtask

  // straightforward DES: cumulative left rotations, keys stored K1..K16
  task automatic gen_ks(input logic [63:0] k);
    logic [27:0] c, d;
    logic [55:0] cd;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = k[64-pc1_t[i]];
      d[27-i] = k[64-pc1_t[i+28]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < shifts[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[r][47-i] = cd[56-pc2_t[i]];
    end
  endtask

  function automatic logic par_bad(input logic [63:0] k);
    logic r = 1'b0;
    for (int b = 0; b < 8; b++) if ($countones(k[8*b +: 8]) % 2 == 0) r = 1'b1;
    return r;
  endfunction

  // mode: 0 = always ready, 1 = random stalls, 2 = three-cycle stall at round 4
  task automatic run_schedule(input logic s, input logic [63:0] k, input logic dec, input int mode,
                              input logic tbl_chk, input logic [47:0] t_first, input logic [47:0] t_last);
    logic [47:0] e [16];
    logic [47:0] got_first, got_last;
    logic rdy;
    int r, n, stalls;
    gen_ks(k);
    for (int i = 0; i < 16; i++) e[i] = dec ? ks[15-i] : ks[i];
    sel = s;
    @(negedge clk);
    chk("offer_idle", {o_key_ready, o_sk_valid}, 2'b10);
    key_valid = 1'b1; key = k; decrypt = dec; sk_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; key = {$urandom, $urandom}; decrypt = ~dec;
    chk("parity_err", o_parity_err, par_bad(k));
    r = 0; n = 0; stalls = 0; got_first = '0; got_last = '0;
    while (r < 16 && n < 200) begin
      chk($sformatf("sk_r%0d", r), {o_sk_valid, o_round, o_sk_last, o_subkey}, {1'b1, 4'(r), r == 15, e[r]});
      if (r == 0) got_first = o_subkey;
      if (r == 15) got_last = o_subkey;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : !(r == 4 && stalls < 3);
      if (mode == 2 && r == 4 && stalls < 3) stalls++;
      sk_ready = rdy;
      if (rdy) r++;
      n++;
      @(negedge clk);
    end
    if (r < 16) chk("schedule_timeout", r, 16);
    chk("done_state", {o_sk_valid, o_sk_last, o_key_ready}, 3'b000);
    @(negedge clk);
    chk("ready_again", {o_sk_valid, o_key_ready}, 2'b01);
    if (tbl_chk) begin
      chk("tbl_first", got_first, t_first);
      chk("tbl_last", got_last, t_last);
    end
  endtask

  initial begin
    tbl[0] = '{64'h133457799BBCDFF1, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
    tbl[1] = '{64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
    tbl[2] = '{64'h0101010101010101, 1'b0, 48'h000000000000, 48'h000000000000};
    tbl[3] = '{64'hFEFEFEFEFEFEFEFE, 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
    k_bad  = 64'h133457799BBCDFF0;
    #1;
    chk("reset_out", {o_key_ready, o_sk_valid, o_sk_last, o_parity_err, o_round, o_subkey},
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 48'd0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_schedule(1'b0, tbl[i].key, tbl[i].dec, 0, 1'b1, tbl[i].first, tbl[i].last);
    run_schedule(1'b0, 64'h133457799BBCDFF1, 1'b0, 2, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) run_schedule(1'b0, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1, 1'b0, '0, '0);
    // flush beats a key offer in IDLE
    @(negedge clk);
    flush = 1'b1; key_valid = 1'b1; key = 64'h0101010101010101;
    #1 chk("flush_blocks_ready", o_key_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0; key_valid = 1'b0;
    chk("flush_no_accept", o_sk_valid, 1'b0);
    // flush at round 7
    @(negedge clk);
    key_valid = 1'b1; key = k_bad; decrypt = 1'b0; sk_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_flush_r7", {o_sk_valid, o_round}, {1'b1, 4'd7});
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush_r7", {o_sk_valid, o_sk_last, o_key_ready, o_parity_err}, 4'b0011);
    // flush together with the final transfer aborts instead of finishing
    @(negedge clk);
    key_valid = 1'b1; key = k_bad; decrypt = 1'b1; sk_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_flush_last", {o_sk_valid, o_round, o_sk_last}, {1'b1, 4'd15, 1'b1});
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush_last", {o_sk_valid, o_sk_last, o_key_ready, o_parity_err}, 4'b0011);
    // reset in the middle of a schedule
    @(negedge clk);
    key_valid = 1'b1; key = k_bad; decrypt = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("reset_mid", {o_key_ready, o_sk_valid, o_sk_last, o_parity_err, o_round, o_subkey},
           {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 48'd0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("no_stray_%0d", i), o_sk_valid, 1'b0);
    end
    // reject mode instance
    sel = 1'b1;
    @(negedge clk);
    chk("rej_offer", o_key_ready, 1'b1);
    key_valid = 1'b1; key = k_bad; decrypt = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    chk("rej_done", {o_parity_err, o_sk_valid, o_key_ready}, 3'b100);
    @(negedge clk);
    chk("rej_idle", {o_sk_valid, o_key_ready}, 2'b01);
    run_schedule(1'b1, 64'h0101010101010101, 1'b0, 0, 1'b1, '0, '0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
